// File: rtl/prog_dumper_pkg.sv
// Shared definitions for the program dumper: address width, UART frame constants,
// FSM state encoding and the checksum trailer helper.
package prog_dumper_pkg;

    localparam int unsigned ADR_W           = 21;
    localparam int unsigned FRAME_BITS      = 10;   // start + 8 data + stop
    localparam logic        UART_START      = 1'b0;
    localparam logic        UART_STOP       = 1'b1;
    localparam int unsigned DEFAULT_CLK_DIV = 104;  // 12 MHz / 115200

    typedef logic [ADR_W-1:0] adr_t;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWaitCts,
        StSend,
        StSum
    } state_t;

    // Trailer byte chosen so that the sum of all data bytes plus the trailer is 0 mod 256.
    function automatic logic [7:0] sum_trailer(input logic [7:0] sum);
        return 8'd0 - sum;
    endfunction

endpackage

// File: rtl/prog_dumper_if.sv
// Host/memory side signals of the program dumper.
//   master: the dumper (drives adr, read, tx, busy, done)
//   slave : the surrounding system (drives start, start_adr, last_adr, cts_in, din)
interface prog_dumper_if;
    import prog_dumper_pkg::*;

    logic       start;
    adr_t       start_adr;
    adr_t       last_adr;
    logic       cts_in;
    logic [7:0] din;
    adr_t       adr;
    logic       read;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        input  start, start_adr, last_adr, cts_in, din,
        output adr, read, tx, busy, done
    );

    modport slave (
        output start, start_adr, last_adr, cts_in, din,
        input  adr, read, tx, busy, done
    );

endinterface

// File: rtl/prog_dumper_uart_tx_core.sv
// UART 8N1 transmitter core.
//   clk, n_reset : clock, asynchronous active-low reset
//   load         : start a frame with data (ignored while a frame is in flight)
//   data         : byte to send, LSB first
//   ready        : high whenever no frame is in flight; rises the cycle after the
//                  stop bit completes
//   tx           : registered serial output, idles high
module uart_tx_core
    import prog_dumper_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

    logic        active_q;
    logic [9:0]  shift_q;
    logic [3:0]  bit_q;
    logic [15:0] baud_q;
    logic        tx_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_q     <= UART_STOP;
        end else if (!active_q) begin
            if (load) begin
                active_q <= 1'b1;
                shift_q  <= {UART_STOP, data, UART_START};
                tx_q     <= UART_START;
                bit_q    <= '0;
                baud_q   <= '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
                active_q <= 1'b0;
                tx_q     <= UART_STOP;
            end else begin
                bit_q   <= bit_q + 4'd1;
                // shift_q[0] is the bit on the line; shift_q[1] is the next one.
                shift_q <= {UART_STOP, shift_q[9:1]};
                tx_q    <= shift_q[1];
            end
        end else begin
            baud_q <= baud_q + 16'd1;
        end
    end

    assign ready = ~active_q;
    assign tx    = tx_q;

endmodule

// File: rtl/prog_dumper.sv
// Program dumper: reads memory from start_adr to last_adr (inclusive, wrapping at
// 2^21) and streams each byte out on UART TX, optionally followed by a checksum byte.
//   clk, n_reset : clock, asynchronous active-low reset
//   bus          : prog_dumper_if.master (start/range/cts/din in; adr/read/tx/busy/done out)
module prog_dumper
    import prog_dumper_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned READ_WAIT = 2,
    parameter bit          SEND_SUM  = 1'b1
) (
    input logic           clk,
    input logic           n_reset,
    prog_dumper_if.master bus
);

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

    state_t     state_q, state_d;
    adr_t       adr_q, adr_d;
    adr_t       last_q, last_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] data_q, data_d;
    logic [3:0] wait_q, wait_d;
    logic       sum_phase_q, sum_phase_d;  // the frame in flight is the checksum

    logic       load;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       done;

    uart_tx_core #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .n_reset(n_reset),
        .load   (load),
        .data   (tx_byte),
        .ready  (tx_ready),
        .tx     (bus.tx)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            adr_q       <= '0;
            last_q      <= '0;
            sum_q       <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            sum_phase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            last_q      <= last_d;
            sum_q       <= sum_d;
            data_q      <= data_d;
            wait_q      <= wait_d;
            sum_phase_q <= sum_phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        last_d      = last_q;
        sum_d       = sum_q;
        data_d      = data_q;
        wait_d      = wait_q;
        sum_phase_d = sum_phase_q;
        load        = 1'b0;
        tx_byte     = data_q;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    adr_d       = bus.start_adr;
                    last_d      = bus.last_adr;
                    sum_d       = '0;
                    wait_d      = '0;
                    sum_phase_d = 1'b0;
                    state_d     = StRead;
                end
            end
            StRead: begin
                if (wait_q == WAIT_LAST) begin
                    data_d  = bus.din;
                    sum_d   = sum_q + bus.din;
                    state_d = StWaitCts;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StWaitCts: begin
                if (bus.cts_in) begin
                    load    = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                // tx_ready in this state means the frame just finished its stop bit.
                if (tx_ready) begin
                    if (sum_phase_q) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else if (adr_q != last_q) begin
                        adr_d   = adr_q + adr_t'(1);
                        wait_d  = '0;
                        state_d = StRead;
                    end else if (SEND_SUM) begin
                        data_d      = sum_trailer(sum_q);
                        sum_phase_d = 1'b1;
                        // This cycle doubles as the first cts check for the trailer.
                        if (bus.cts_in) begin
                            load    = 1'b1;
                            tx_byte = sum_trailer(sum_q);
                        end else begin
                            state_d = StSum;
                        end
                    end else begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StSum: begin
                if (bus.cts_in) begin
                    load    = 1'b1;
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.adr  = adr_q;
    assign bus.read = (state_q == StRead);
    assign bus.busy = (state_q != StIdle) && !done;
    assign bus.done = done;

endmodule
